// File: rtl/tile_weight_accum_pkg.sv
// Shared definitions for the gaussian tile pipeline (coefficient stage and weight accumulator).
//   tile_state_e : accumulator control states
//   FxOne        : fixed-point 1.0 for the default 16 fractional bits
//   fx_one()     : fixed-point 1.0 for an arbitrary fractional width
//   fx_mul()     : signed fixed-point multiply, truncating, rescaled by frac_bits
package tile_weight_accum_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StDrain
   } tile_state_e;

   // Operands up to this width are supported by the helper functions.
   localparam int unsigned FxMaxWidth = 64;
   localparam int unsigned FxFracBits = 16;
   localparam logic [FxMaxWidth-1:0] FxOne = FxMaxWidth'(1) << FxFracBits;

   function automatic logic [FxMaxWidth-1:0] fx_one(input int unsigned frac_bits);
      return FxMaxWidth'(1) << frac_bits;
   endfunction

   // Full-precision product, arithmetic shift by frac_bits, low FxMaxWidth bits returned.
   // Callers narrow the result to their own data width.
   function automatic logic signed [FxMaxWidth-1:0] fx_mul(input logic signed [FxMaxWidth-1:0] a,
                                                         input logic signed [FxMaxWidth-1:0] b,
                                                         input int unsigned frac_bits);
      logic signed [2*FxMaxWidth-1:0] full;
      full = ((2*FxMaxWidth)'(a) * (2*FxMaxWidth)'(b)) >>> frac_bits;
      return FxMaxWidth'(full);
   endfunction

endpackage

// File: rtl/tile_weight_lane.sv
// One pixel of a tile row: evaluates the gaussian exponent, converts it to a clamped linear
// weight and adds it to the pixel accumulator with unsigned saturation. Purely combinational.
//   a, b     : per-column x term and per-row y term (signed fixed point)
//   c, d     : per-column and per-row cross factors (signed fixed point)
//   acc      : current accumulator value
//   acc_next : saturated accumulator + weight
//   sat      : the addition overflowed and was clamped
module tile_weight_lane import tile_weight_accum_pkg::*; #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FRAC_BITS  = 16
) (
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   input  logic signed [DATA_WIDTH-1:0] c,
   input  logic signed [DATA_WIDTH-1:0] d,
   input  logic        [DATA_WIDTH-1:0] acc,
   output logic        [DATA_WIDTH-1:0] acc_next,
   output logic                         sat
);

   // Two guard bits: the sum of three DATA_WIDTH terms cannot wrap.
   localparam int unsigned PW = DATA_WIDTH + 2;
   localparam logic signed [PW-1:0] One = PW'(fx_one(FRAC_BITS));

   logic signed [DATA_WIDTH-1:0] prod;
   logic signed [PW-1:0]         p;
   logic signed [PW-1:0]         q;
   logic        [DATA_WIDTH-1:0] w;
   logic        [DATA_WIDTH:0]   sum;

   always_comb begin
      prod = DATA_WIDTH'(fx_mul(FxMaxWidth'(c), FxMaxWidth'(d), FRAC_BITS));
      p    = PW'(a) + PW'(b) + PW'(prod);
      // exp(p) ~ 1 + p/4, linear over p in [-4, 0], clamped to [0, 1]
      q    = One + (p >>> 2);
      if (q[PW-1]) begin
         w = '0;
      end else if (q > One) begin
         w = DATA_WIDTH'(One);
      end else begin
         w = DATA_WIDTH'(q);
      end
      sum      = {1'b0, acc} + {1'b0, w};
      sat      = sum[DATA_WIDTH];
      acc_next = sat ? '1 : sum[DATA_WIDTH-1:0];
   end

endmodule

// File: rtl/tile_weight_accum.sv
// Per-tile gaussian weight accumulator. Accepts one coefficient set (A/B/C/D vectors) at a time,
// evaluates it over the TILE_SIZE x TILE_SIZE tile one row per cycle and accumulates the clamped
// weights. After the gaussian flagged end_of_tile, the tile is streamed out row by row and each
// row is cleared as it is accepted.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : coefficient set handshake; end_of_tile sampled at accept
//   A_values, C_values   : per-column terms;  B_values, D_values : per-row terms
//   out_valid / out_ready: tile row handshake; out_row, out_last, out_pixels describe the row
//   sat_count            : only with TILE_WEIGHT_SAT_CNT_EN defined; saturating count of pixel
//                          updates that clamped, cleared when the last row is accepted
// TILE_SIZE must be a power of two, at least 2.
module tile_weight_accum import tile_weight_accum_pkg::*; #(
   parameter int unsigned TILE_SIZE  = 16,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FRAC_BITS  = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         end_of_tile,
   input  logic signed [DATA_WIDTH-1:0] A_values [TILE_SIZE],
   input  logic signed [DATA_WIDTH-1:0] B_values [TILE_SIZE],
   input  logic signed [DATA_WIDTH-1:0] C_values [TILE_SIZE],
   input  logic signed [DATA_WIDTH-1:0] D_values [TILE_SIZE],
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(TILE_SIZE)-1:0] out_row,
   output logic                         out_last,
   output logic        [DATA_WIDTH-1:0] out_pixels [TILE_SIZE]
`ifdef TILE_WEIGHT_SAT_CNT_EN
   ,
   output logic [15:0]                  sat_count
`endif
);

   localparam int unsigned RowW = $clog2(TILE_SIZE);

   tile_state_e state_q, state_d;

   logic signed [DATA_WIDTH-1:0] a_q [TILE_SIZE];
   logic signed [DATA_WIDTH-1:0] b_q [TILE_SIZE];
   logic signed [DATA_WIDTH-1:0] c_q [TILE_SIZE];
   logic signed [DATA_WIDTH-1:0] d_q [TILE_SIZE];
   logic [DATA_WIDTH-1:0]        acc_q [TILE_SIZE][TILE_SIZE];
   logic                         eot_q;
   logic [RowW-1:0]              y_q;

   logic [DATA_WIDTH-1:0] lane_acc [TILE_SIZE];
   logic [TILE_SIZE-1:0]  lane_sat;

   logic accept, drain_pop, row_last;

   assign accept    = in_valid && in_ready;
   assign drain_pop = out_valid && out_ready;
   assign row_last  = (y_q == RowW'(TILE_SIZE - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) state_d = StAccum;
         end
         StAccum: begin
            if (row_last) state_d = eot_q ? StDrain : StIdle;
         end
         StDrain: begin
            out_valid = 1'b1;
            if (out_ready && row_last) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Row y is evaluated by all lanes in parallel; the row counter wraps to 0 after the last row,
   // which leaves it ready for the drain or the next gaussian.
   for (genvar x = 0; x < TILE_SIZE; x++) begin : g_lane
      tile_weight_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .FRAC_BITS  (FRAC_BITS)
      ) u_lane (
         .a        (a_q[x]),
         .b        (b_q[y_q]),
         .c        (c_q[x]),
         .d        (d_q[y_q]),
         .acc      (acc_q[y_q][x]),
         .acc_next (lane_acc[x]),
         .sat      (lane_sat[x])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TILE_SIZE; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
            c_q[i] <= '0;
            d_q[i] <= '0;
            for (int j = 0; j < TILE_SIZE; j++) acc_q[i][j] <= '0;
         end
         eot_q <= 1'b0;
         y_q   <= '0;
      end else begin
         if (accept) begin
            a_q   <= A_values;
            b_q   <= B_values;
            c_q   <= C_values;
            d_q   <= D_values;
            eot_q <= end_of_tile;
            y_q   <= '0;
         end
         if (state_q == StAccum) begin
            for (int x = 0; x < TILE_SIZE; x++) acc_q[y_q][x] <= lane_acc[x];
            y_q <= y_q + RowW'(1);
         end
         if (drain_pop) begin
            for (int x = 0; x < TILE_SIZE; x++) acc_q[y_q][x] <= '0;
            y_q <= y_q + RowW'(1);
         end
      end
   end

   // Row outputs are forced to zero outside the drain so they hold their reset values.
   always_comb begin
      out_row  = '0;
      out_last = 1'b0;
      for (int x = 0; x < TILE_SIZE; x++) out_pixels[x] = '0;
      if (state_q == StDrain) begin
         out_row  = y_q;
         out_last = row_last;
         for (int x = 0; x < TILE_SIZE; x++) out_pixels[x] = acc_q[y_q][x];
      end
   end

`ifdef TILE_WEIGHT_SAT_CNT_EN
   localparam int unsigned PopW = RowW + 1;

   logic [15:0]     sat_cnt_q;
   logic [PopW-1:0] sat_pop;
   logic [16:0]     sat_sum;

   always_comb begin
      sat_pop = '0;
      for (int x = 0; x < TILE_SIZE; x++) sat_pop = sat_pop + PopW'(lane_sat[x]);
      sat_sum = 17'(sat_cnt_q) + 17'(sat_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_cnt_q <= '0;
      end else if (state_q == StAccum) begin
         sat_cnt_q <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end else if (drain_pop && row_last) begin
         sat_cnt_q <= '0;
      end
   end

   assign sat_count = sat_cnt_q;
`else
   logic unused_sat;
   assign unused_sat = ^lane_sat;
`endif

endmodule

// File: tb/tb_tile_weight_accum.sv
module tb_tile_weight_accum;

   localparam int TS = 16;
   localparam int DW = 32;
   localparam longint ONE = 65536;

   typedef struct packed {
      logic [3:0]             row;
      logic                   last;
      logic [TS-1:0][DW-1:0]  pix;
   } row_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic end_of_tile = 1'b0;
   logic out_ready = 1'b1;
   logic in_ready, out_valid, out_last;
   logic [3:0] out_row;
   logic [DW-1:0] out_pixels [TS];
   logic signed [DW-1:0] a_v [TS];
   logic signed [DW-1:0] b_v [TS];
   logic signed [DW-1:0] c_v [TS];
   logic signed [DW-1:0] d_v [TS];

   int checks = 0;
   int failures = 0;
   row_t exp_q[$];
   longint macc [TS][TS];
   row_t mon_obs, mon_exp;

   tile_weight_accum #(
      .TILE_SIZE  (TS),
      .DATA_WIDTH (DW),
      .FRAC_BITS  (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .end_of_tile (end_of_tile),
      .A_values    (a_v),
      .B_values    (b_v),
      .C_values    (c_v),
      .D_values    (d_v),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_row     (out_row),
      .out_last    (out_last),
      .out_pixels  (out_pixels)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // Reference pixel weight, written independently with 64-bit arithmetic.
   function automatic longint weight(input int a, input int b, input int c, input int d);
      longint prod, p, q;
      prod = (longint'(c) * longint'(d)) >>> 16;
      prod = longint'(int'(prod));
      p = longint'(a) + longint'(b) + prod;
      q = ONE + (p >>> 2);
      if (q < 0) return 0;
      if (q > ONE) return ONE;
      return q;
   endfunction

   task automatic model_clear();
      for (int y = 0; y < TS; y++)
         for (int x = 0; x < TS; x++) macc[y][x] = 0;
   endtask

   task automatic model_add(input bit eot);
      row_t r;
      for (int y = 0; y < TS; y++)
         for (int x = 0; x < TS; x++) begin
            macc[y][x] = macc[y][x] + weight(a_v[x], b_v[y], c_v[x], d_v[y]);
            if (macc[y][x] > 64'hFFFF_FFFF) macc[y][x] = 64'hFFFF_FFFF;
         end
      if (eot) begin
         for (int y = 0; y < TS; y++) begin
            r.row = 4'(y);
            r.last = (y == TS - 1);
            for (int x = 0; x < TS; x++) r.pix[x] = macc[y][x][31:0];
            exp_q.push_back(r);
         end
         model_clear();
      end
   endtask

   task automatic set_all(input int a, input int b, input int c, input int d);
      for (int i = 0; i < TS; i++) begin
         a_v[i] = a; b_v[i] = b; c_v[i] = c; d_v[i] = d;
      end
   endtask

   // Waits for in_ready, presents one coefficient set and returns just after the accepting edge.
   task automatic send(input bit eot);
      bit ok = 1'b0;
      model_add(eot);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL accept_wait in_ready=%0b required 1 within 100 cycles", in_ready);
      end
      in_valid = 1'b1;
      end_of_tile = eot;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      end_of_tile = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid) break;
      end
   endtask

   // Scoreboard: every accepted output row is popped against the model.
   always begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid && out_ready) begin
         mon_obs.row = out_row;
         mon_obs.last = out_last;
         for (int x = 0; x < TS; x++) mon_obs.pix[x] = out_pixels[x];
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_row got row=%0d last=%0b, required no output", out_row,
                     out_last);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_obs !== mon_exp) begin
               failures++;
               $display("FAIL row_data got row=%0d last=%0b pix=%h required row=%0d last=%0b pix=%h",
                        mon_obs.row, mon_obs.last, mon_obs.pix, mon_exp.row, mon_exp.last,
                        mon_exp.pix);
            end
         end
      end
   end

   task automatic test_reset();
      logic nz;
      @(negedge clk);
      nz = 1'b0;
      for (int x = 0; x < TS; x++) nz |= (out_pixels[x] !== '0);
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %0b required 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0b required 0", out_valid); end
      checks++;
      if (out_row !== 4'd0) begin failures++; $display("FAIL reset_out_row got %0d required 0", out_row); end
      checks++;
      if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got %0b required 0", out_last); end
      checks++;
      if (nz) begin failures++; $display("FAIL reset_out_pixels got nonzero required all 0"); end
   endtask

   task automatic test_zero_tile();
      int lowcnt = 0;
      int first_ov = 0;
      set_all(0, 0, 0, 0);
      send(1'b1);
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (out_valid && first_ov == 0) first_ov = k;
         if (in_ready) break;
         lowcnt++;
      end
      checks++;
      if (lowcnt != 2 * TS) begin failures++; $display("FAIL zero_busy_cycles got %0d required %0d", lowcnt, 2 * TS); end
      checks++;
      if (first_ov != TS + 1) begin failures++; $display("FAIL zero_first_out_valid got %0d required %0d", first_ov, TS + 1); end
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL zero_rows_left got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_clamp_low();
      set_all(-262144, 0, 0, 0);
      send(1'b1);
      wait_drain();
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL clamp_low_rows_left got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_column();
      set_all(0, 0, 0, 0);
      a_v[3] = -131072;
      send(1'b1);
      wait_drain();
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL column_rows_left got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      int lowcnt = 0;
      set_all(0, 0, 0, 0);
      send(1'b0);
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (in_ready) break;
         lowcnt++;
      end
      checks++;
      if (lowcnt != TS) begin failures++; $display("FAIL b2b_busy_cycles got %0d required %0d", lowcnt, TS); end
      send(1'b1);
      wait_drain();
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_rows_left got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_stall();
      int dv = 0;
      int stall = 0;
      bit done = 1'b0;
      bit bad;
      set_all(0, 0, 0, 0);
      send(1'b1);
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (out_valid) begin
            dv++;
            if (stall > 0 && stall <= 3) begin
               bad = (out_row !== 4'd5);
               for (int x = 0; x < TS; x++) bad |= (out_pixels[x] !== 32'd65536);
               checks++;
               if (bad) begin
                  failures++;
                  $display("FAIL stall_hold got row=%0d pix0=%0d required row=5 pix=65536",
                           out_row, out_pixels[0]);
               end
               stall++;
               if (stall == 4) out_ready = 1'b1;
            end else if (stall == 0 && out_row == 4'd5) begin
               out_ready = 1'b0;
               stall = 1;
            end
            if (out_last && out_ready) done = 1'b1;
         end
      end
      out_ready = 1'b1;
      wait_drain();
      checks++;
      if (dv != TS + 3) begin failures++; $display("FAIL stall_drain_cycles got %0d required %0d", dv, TS + 3); end
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL stall_rows_left got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid_accum();
      set_all(-131072, 0, 0, 0);
      send(1'b1);
      repeat (8) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got %0b required 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got %0b required 1", in_ready); end
      exp_q.delete();
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      set_all(0, 0, 0, 0);
      send(1'b1);
      wait_drain();
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL midrst_rows_left got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_random();
      for (int g = 0; g < 3; g++) begin
         for (int i = 0; i < TS; i++) begin
            a_v[i] = int'($urandom_range(0, 655360)) - 327680;
            b_v[i] = int'($urandom_range(0, 655360)) - 327680;
            c_v[i] = int'($urandom_range(0, 262144)) - 131072;
            d_v[i] = int'($urandom_range(0, 262144)) - 131072;
         end
         send(g == 2);
      end
      wait_drain();
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL random_rows_left got %0d required 0", exp_q.size()); end
   endtask

   initial begin
      set_all(0, 0, 0, 0);
      model_clear();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_zero_tile();
      test_clamp_low();
      test_column();
      test_back_to_back();
      test_stall();
      test_reset_mid_accum();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
